if_fetch_unit: RTL and testbench

Instruction-fetch stage that owns the program counter. It sits directly downstream of the branch unit, which supplies the redirect target, and upstream of decode. Each cycle it either advances the PC by 4 or loads the resolved redirect target. It issues single-outstanding reads to instruction memory over a req/gnt/rvalid handshake. Returned words are buffered in a small FIFO and presented to decode with valid/ready, each tagged with its PC.

---
 rtl/if_fetch_unit.sv | 194 +++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage. Owns the program counter, issues single-outstanding
// reads to instruction memory and buffers returned words (tagged with their
// PC) in a small FIFO that feeds decode.
//
// Ports:
//   clk             clock, all state on rising edge
//   rst             synchronous active-high reset
//   fetch_en        1 = allowed to issue new requests
//   redirect_valid  branch unit supplies a non-sequential next PC this cycle
//   redirect_pc     redirect target (bits [1:0] ignored)
//   imem_req        read request, held until imem_gnt
//   imem_addr       word-aligned read address
//   imem_gnt        request accepted this cycle
//   imem_rvalid     read data valid
//   imem_rdata      instruction word
//   if_valid        buffer head valid
//   if_instr        buffer head instruction
//   if_pc           PC of buffer head
//   if_ready        decode accepts head when if_valid && if_ready
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0008,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FLUSH
    } state_t;

    state_t             state;
    logic [31:0]        fetch_pc;
    logic [31:0]        req_pc;
    logic [31:0]        pend_pc;
    logic               pend_redirect;
    logic               outstanding;

    logic [31:0]        buf_instr [BUF_DEPTH];
    logic [31:0]        buf_pc    [BUF_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;

    logic               push;
    logic               pop;
    logic               in_flight;
    logic               issue_ok;
    logic [31:0]        redirect_tgt;

    // Low address bits of the redirect target are forced to zero.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = &{1'b0, redirect_pc[1:0]};

    assign redirect_tgt = {redirect_pc[31:2], 2'b00};

    // Only a response in S_WAIT is live; S_FLUSH responses and anything
    // coinciding with a redirect are stale and dropped.
    assign push = (state == S_WAIT) && imem_rvalid && !redirect_valid;
    assign pop  = if_valid && if_ready;

    // A request still outstanding after this cycle occupies a buffer slot.
    assign in_flight = outstanding && !imem_rvalid;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // A redirect empties the buffer, so only fetch_en matters then.
    assign issue_ok = fetch_en &&
                      (redirect_valid ||
                       ((count_nxt + CNT_W'(in_flight)) < CNT_W'(BUF_DEPTH)));

    assign imem_req  = (state == S_REQ);
    assign imem_addr = fetch_pc;

    assign if_valid  = (count != '0);
    assign if_instr  = if_valid ? buf_instr[rd_ptr] : 32'h0;
    assign if_pc     = if_valid ? buf_pc[rd_ptr]    : 32'h0;

    // Control state: FSM, PC, buffer pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            fetch_pc      <= RESET_PC;
            outstanding   <= 1'b0;
            pend_redirect <= 1'b0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
        end else begin
            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count_nxt;
            end

            case (state)
                S_IDLE: begin
                    if (redirect_valid) fetch_pc <= redirect_tgt;
                    if (issue_ok)       state    <= S_REQ;
                end

                S_REQ: begin
                    if (imem_gnt) begin
                        outstanding   <= 1'b1;
                        pend_redirect <= 1'b0;
                        if (redirect_valid) begin
                            fetch_pc <= redirect_tgt;
                            state    <= S_FLUSH;
                        end else if (pend_redirect) begin
                            fetch_pc <= pend_pc;
                            state    <= S_FLUSH;
                        end else begin
                            fetch_pc <= fetch_pc + 32'd4;
                            state    <= S_WAIT;
                        end
                    end else if (redirect_valid) begin
                        // Address must not change under an ungranted request;
                        // remember the target and apply it once granted.
                        pend_redirect <= 1'b1;
                    end
                end

                S_WAIT: begin
                    if (redirect_valid) fetch_pc <= redirect_tgt;
                    if (imem_rvalid) begin
                        outstanding <= 1'b0;
                        state       <= issue_ok ? S_REQ : S_IDLE;
                    end else if (redirect_valid) begin
                        state <= S_FLUSH;
                    end
                end

                S_FLUSH: begin
                    if (redirect_valid) fetch_pc <= redirect_tgt;
                    if (imem_rvalid) begin
                        outstanding <= 1'b0;
                        state       <= issue_ok ? S_REQ : S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // Data state: buffer contents and captured addresses carry no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]    <= req_pc;
        end
        if ((state == S_REQ) && imem_gnt) begin
            req_pc <= fetch_pc;
        end
        if ((state == S_REQ) && !imem_gnt && redirect_valid) begin
            pend_pc <= redirect_tgt;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .RESET_PC  (32'h0000_0008),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready)
    );

    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs [8];

    int checks   = 0;
    int failures = 0;

    // Memory responder state (active when auto_mem is set).
    bit          auto_mem;
    int          rsp_lat;
    int          pend_cnt;
    logic [31:0] pend_addr;
    logic [31:0] hold_addr;
    int          hold_cnt;
    int          n_gnt;
    bit          found;
    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_pop_q  [$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, 16'h0013};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Advance one clock. Pops are observed just before the edge that takes
    // them; the responder drives gnt/rvalid just after the edge.
    task automatic tick();
        if (auto_mem && if_valid && if_ready) begin
            chk("pop_instr", if_instr, instr_of(if_pc));
            if (exp_pop_q.size() > 0) chk("pop_pc", if_pc, exp_pop_q.pop_front());
        end
        @(posedge clk);
        #1;
        if (auto_mem) begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = instr_of(pend_addr);
                end
            end
            imem_gnt = 1'b0;
            if (imem_req) begin
                if (imem_addr == hold_addr && hold_cnt > 0) begin
                    hold_cnt--;
                end else begin
                    imem_gnt  = 1'b1;
                    pend_cnt  = rsp_lat;
                    pend_addr = imem_addr;
                    n_gnt++;
                    if (exp_addr_q.size() > 0) chk("req_addr", imem_addr, exp_addr_q.pop_front());
                end
            end
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        auto_mem       = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        pend_cnt       = 0;
        hold_addr      = 32'hFFFF_FFFF;
        hold_cnt       = 0;
        n_gnt          = 0;
        rsp_lat        = 1;
        exp_addr_q.delete();
        exp_pop_q.delete();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        //             gnt rv  rdata         rdy req addr          vld pc            instr
        vecs[0] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        1'b0, 32'h0,        32'h0};
        vecs[2] = '{1'b0, 1'b1, 32'h00000013, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC,        1'b1, 32'h8,        32'h00000013};
        vecs[4] = '{1'b0, 1'b1, 32'h00000013, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h10,       1'b1, 32'hC,        32'h00000013};
        vecs[6] = '{1'b0, 1'b1, 32'h00000013, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0};
        vecs[7] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h14,       1'b1, 32'h10,       32'h00000013};

        fetch_en = 1'b1;
        if_ready = 1'b1;

        // ---- reset state and sequential fetch table ----
        do_reset();
        chk("rst_req",   imem_req, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_instr", if_instr, 0);
        chk("rst_pc",    if_pc,    0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("v%0d_req", i),   imem_req, vecs[i].exp_req);
            if (vecs[i].exp_req) chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_valid", i), if_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_pc", i),    if_pc,    vecs[i].exp_pc);
                chk($sformatf("v%0d_instr", i), if_instr, vecs[i].exp_instr);
            end
            imem_gnt    = vecs[i].gnt;
            imem_rvalid = vecs[i].rvalid;
            imem_rdata  = vecs[i].rdata;
            if_ready    = vecs[i].ready;
            tick();
        end

        // ---- decode stall: buffer fills, fetch stops, then resumes ----
        do_reset();
        fetch_en = 1'b1;
        if_ready = 1'b0;
        auto_mem = 1'b1;
        exp_addr_q = '{32'h8, 32'hC, 32'h10, 32'h14};
        exp_pop_q  = '{32'h8, 32'hC, 32'h10};
        repeat (12) tick();
        chk("stall_fetches", 32'(n_gnt), 2);
        chk("stall_req",     imem_req, 0);
        chk("stall_valid",   if_valid, 1);
        chk("stall_head_pc", if_pc, 32'h8);
        if_ready = 1'b1;
        repeat (12) tick();
        chk("stall_addr_left", 32'(exp_addr_q.size()), 0);
        chk("stall_pop_left",  32'(exp_pop_q.size()), 0);

        // ---- redirect while waiting for 0x10 (latency 2, flush path) ----
        do_reset();
        rsp_lat  = 2;
        auto_mem = 1'b1;
        exp_addr_q = '{32'h8, 32'hC, 32'h10, 32'h100, 32'h104};
        exp_pop_q  = '{32'h8, 32'hC, 32'h100};
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (imem_gnt && imem_addr == 32'h10) found = 1'b1;
        end
        chk("rdw_found", 32'(found), 1);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        chk("rdw_empty", if_valid, 0);
        tick();
        chk("rdw_drop",  if_valid, 0);
        chk("rdw_req",   imem_req, 1);
        chk("rdw_addr",  imem_addr, 32'h100);
        repeat (10) tick();
        chk("rdw_addr_left", 32'(exp_addr_q.size()), 0);
        chk("rdw_pop_left",  32'(exp_pop_q.size()), 0);

        // ---- redirect while request to 0x10 is held ungranted ----
        do_reset();
        rsp_lat   = 1;
        auto_mem  = 1'b1;
        hold_addr = 32'h10;
        hold_cnt  = 3;
        exp_addr_q = '{32'h8, 32'hC, 32'h10, 32'h200, 32'h204};
        exp_pop_q  = '{32'h8, 32'hC, 32'h200};
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (imem_req && imem_addr == 32'h10) found = 1'b1;
        end
        chk("rdh_found", 32'(found), 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rdh_req%0d", k),   imem_req, 1);
            chk($sformatf("rdh_addr%0d", k),  imem_addr, 32'h10);
            chk($sformatf("rdh_valid%0d", k), if_valid, 0);
            tick();
        end
        chk("rdh_flush_req",   imem_req, 0);
        chk("rdh_flush_valid", if_valid, 0);
        tick();
        chk("rdh_new_addr",  imem_addr, 32'h200);
        chk("rdh_new_valid", if_valid, 0);
        repeat (10) tick();
        chk("rdh_addr_left", 32'(exp_addr_q.size()), 0);
        chk("rdh_pop_left",  32'(exp_pop_q.size()), 0);

        // ---- redirect from idle to the top of the address space ----
        do_reset();
        fetch_en = 1'b0;
        auto_mem = 1'b1;
        tick();
        tick();
        chk("wrap_idle_req", imem_req, 0);
        exp_addr_q = '{32'hFFFF_FFFC, 32'h0, 32'h4};
        exp_pop_q  = '{32'hFFFF_FFFC, 32'h0};
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        fetch_en       = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_req",  imem_req, 1);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        repeat (10) tick();
        chk("wrap_addr_left", 32'(exp_addr_q.size()), 0);
        chk("wrap_pop_left",  32'(exp_pop_q.size()), 0);

        // ---- reset during S_WAIT, late rvalid ignored ----
        do_reset();
        fetch_en = 1'b1;
        if_ready = 1'b1;
        tick();
        chk("rsw_req",  imem_req, 1);
        chk("rsw_addr", imem_addr, 32'h8);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("rsw_wait_req", imem_req, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rsw_rst_valid", if_valid, 0);
        chk("rsw_rst_req",   imem_req, 0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        chk("rsw_ign_valid", if_valid, 0);
        chk("rsw_re_req",    imem_req, 1);
        chk("rsw_re_addr",   imem_addr, 32'h8);
        tick();
        chk("rsw_still_empty", if_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
